// File: rtl/skin_div_arbiter_if.sv
// skin_div_arbiter_if
//   Bundles the two requester handshakes (Cb, Cr), the shared divider
//   issue/return bus, the two result strobes and the busy flag.
//   slave  : arbiter view (takes requests, drives divider and results)
//   master : environment view (requesters, divider core, result sinks)
interface skin_div_arbiter_if #(
    parameter int DW = 18
);
    logic          cb_req_valid;
    logic          cb_req_ready;
    logic [DW-1:0] cb_dividend;
    logic [DW-1:0] cb_divisor;
    logic          cr_req_valid;
    logic          cr_req_ready;
    logic [DW-1:0] cr_dividend;
    logic [DW-1:0] cr_divisor;
    logic          div_rfd;
    logic          div_nd;
    logic [DW-1:0] div_dividend;
    logic [DW-1:0] div_divisor;
    logic [DW-1:0] div_quotient;
    logic          cb_res_valid;
    logic [DW-1:0] cb_res_quotient;
    logic          cr_res_valid;
    logic [DW-1:0] cr_res_quotient;
    logic          busy;

    modport slave (
        input  cb_req_valid, cb_dividend, cb_divisor,
        input  cr_req_valid, cr_dividend, cr_divisor,
        input  div_rfd, div_quotient,
        output cb_req_ready, cr_req_ready,
        output div_nd, div_dividend, div_divisor,
        output cb_res_valid, cb_res_quotient,
        output cr_res_valid, cr_res_quotient,
        output busy
    );

    modport master (
        output cb_req_valid, cb_dividend, cb_divisor,
        output cr_req_valid, cr_dividend, cr_divisor,
        output div_rfd, div_quotient,
        input  cb_req_ready, cr_req_ready,
        input  div_nd, div_dividend, div_divisor,
        input  cb_res_valid, cb_res_quotient,
        input  cr_res_valid, cr_res_quotient,
        input  busy
    );
endinterface

// File: rtl/skin_div_arbiter.sv
// skin_div_arbiter
//   Shares one fixed-latency pipelined divider between the Cb and Cr
//   transform paths. Round-robin grant, one request per cycle; a tag
//   pipeline running in lock-step with the divider remembers the owner
//   and divide-by-zero status of each in-flight slot and steers the
//   returning quotient to the right result register.
// Ports:
//   clk  - clock
//   rst  - synchronous active-high reset
//   bus  - skin_div_arbiter_if.slave: Cb/Cr request handshakes, divider
//          issue (div_rfd/div_nd/operands) and return (div_quotient),
//          Cb/Cr result strobes + quotients, busy
// DIV_LATENCY must be >= 2.
module skin_div_arbiter #(
    parameter int DW          = 18,
    parameter int DIV_LATENCY = 20
) (
    input  logic              clk,
    input  logic              rst,
    skin_div_arbiter_if.slave bus
);
    localparam int LAST = DIV_LATENCY - 1;

    // priority pointer: 0 = Cb wins a tie, 1 = Cr wins a tie
    logic ptr_q, ptr_d;

    // tag pipeline, bit i = stage i
    logic [DIV_LATENCY-1:0] tag_vld_q, tag_vld_d;
    logic [DIV_LATENCY-1:0] tag_own_q, tag_own_d;
    logic [DIV_LATENCY-1:0] tag_zero_q, tag_zero_d;

    logic          cb_res_valid_q, cb_res_valid_d;
    logic          cr_res_valid_q, cr_res_valid_d;
    logic [DW-1:0] cb_res_quotient_q, cb_res_quotient_d;
    logic [DW-1:0] cr_res_quotient_q, cr_res_quotient_d;
    logic          busy_q, busy_d;

    logic          grant_cb, grant_cr;
    logic [DW-1:0] issue_dividend, issue_divisor;
    logic [DW-1:0] ret_quotient;

    always_comb begin
        // Grant is combinational in the request cycle; rst masks it so
        // nothing is issued while the tag pipeline is being cleared.
        grant_cb = ~rst & bus.div_rfd & bus.cb_req_valid
                 & (~bus.cr_req_valid | ~ptr_q);
        grant_cr = ~rst & bus.div_rfd & bus.cr_req_valid
                 & (~bus.cb_req_valid | ptr_q);

        ptr_d = ptr_q;
        if (grant_cb)      ptr_d = 1'b1;
        else if (grant_cr) ptr_d = 1'b0;

        issue_dividend = '0;
        issue_divisor  = '0;
        if (grant_cb) begin
            issue_dividend = bus.cb_dividend;
            issue_divisor  = bus.cb_divisor;
        end else if (grant_cr) begin
            issue_dividend = bus.cr_dividend;
            issue_divisor  = bus.cr_divisor;
        end

        // Tags shift every cycle regardless of div_rfd so they stay
        // aligned with the divider's own pipeline.
        tag_vld_d  = {tag_vld_q[LAST-1:0],  grant_cb | grant_cr};
        tag_own_d  = {tag_own_q[LAST-1:0],  grant_cr};
        tag_zero_d = {tag_zero_q[LAST-1:0], (grant_cb | grant_cr) & (issue_divisor == '0)};

        // Divide-by-zero slots return all-ones whatever the core produced.
        ret_quotient = tag_zero_q[LAST] ? {DW{1'b1}} : bus.div_quotient;

        cb_res_valid_d    = tag_vld_q[LAST] & ~tag_own_q[LAST];
        cr_res_valid_d    = tag_vld_q[LAST] &  tag_own_q[LAST];
        cb_res_quotient_d = cb_res_valid_d ? ret_quotient : cb_res_quotient_q;
        cr_res_quotient_d = cr_res_valid_d ? ret_quotient : cr_res_quotient_q;

        // Built from next-state values so busy falls the cycle after the
        // last result strobe.
        busy_d = (|tag_vld_d) | cb_res_valid_d | cr_res_valid_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q             <= 1'b0;
            tag_vld_q         <= '0;
            tag_own_q         <= '0;
            tag_zero_q        <= '0;
            cb_res_valid_q    <= 1'b0;
            cr_res_valid_q    <= 1'b0;
            cb_res_quotient_q <= '0;
            cr_res_quotient_q <= '0;
            busy_q            <= 1'b0;
        end else begin
            ptr_q             <= ptr_d;
            tag_vld_q         <= tag_vld_d;
            tag_own_q         <= tag_own_d;
            tag_zero_q        <= tag_zero_d;
            cb_res_valid_q    <= cb_res_valid_d;
            cr_res_valid_q    <= cr_res_valid_d;
            cb_res_quotient_q <= cb_res_quotient_d;
            cr_res_quotient_q <= cr_res_quotient_d;
            busy_q            <= busy_d;
        end
    end

    assign bus.cb_req_ready    = grant_cb;
    assign bus.cr_req_ready    = grant_cr;
    assign bus.div_nd          = grant_cb | grant_cr;
    assign bus.div_dividend    = issue_dividend;
    assign bus.div_divisor     = issue_divisor;
    assign bus.cb_res_valid    = cb_res_valid_q;
    assign bus.cr_res_valid    = cr_res_valid_q;
    assign bus.cb_res_quotient = cb_res_quotient_q;
    assign bus.cr_res_quotient = cr_res_quotient_q;
    assign bus.busy            = busy_q;
endmodule

// File: tb/tb_skin_div_arbiter.sv
module tb_skin_div_arbiter;
    localparam int DW  = 18;
    localparam int LAT = 20;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    skin_div_arbiter_if #(.DW(DW)) bus ();

    skin_div_arbiter #(.DW(DW), .DIV_LATENCY(LAT)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Divider core model: fixed latency, garbage on idle slots and on /0.
    logic [DW-1:0] dv_q [LAT];
    always @(posedge clk) begin
        for (int i = LAT - 1; i > 0; i--) dv_q[i] <= dv_q[i-1];
        if (bus.div_nd && bus.div_divisor != '0)
            dv_q[0] <= bus.div_dividend / bus.div_divisor;
        else
            dv_q[0] <= DW'($urandom);
    end
    assign bus.div_quotient = dv_q[LAT-1];

    // Reference model: expected results in grant order with due cycle.
    typedef struct {
        bit            side;   // 0 = Cb, 1 = Cr
        logic [DW-1:0] q;
        int            due;
    } exp_t;
    exp_t sb[$];

    int            checks = 0;
    int            failures = 0;
    int            cyc = 0;
    bit            prio_cr = 0;
    bit            last_gcb = 0, last_gcr = 0;
    logic [DW-1:0] last_cb = '0, last_cr = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s cyc=%0d obs=%0h exp=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic drive(input bit cv, input int cdd, input int cds,
                         input bit rv, input int rdd, input int rds, input bit rfd);
        bus.cb_req_valid = cv;
        bus.cb_dividend  = DW'(cdd);
        bus.cb_divisor   = DW'(cds);
        bus.cr_req_valid = rv;
        bus.cr_dividend  = DW'(rdd);
        bus.cr_divisor   = DW'(rds);
        bus.div_rfd      = rfd;
    endtask

    task automatic idle(input int n);
        drive(0, 0, 0, 0, 0, 0, 1);
        repeat (n) tick();
    endtask

    // One clock cycle: check everything at the negedge, update the model,
    // then step past the posedge so the caller can drive the next cycle.
    task automatic tick();
        bit            gcb, gcr, ecbv, ecrv, ebusy;
        logic [DW-1:0] edd, eds;
        @(negedge clk);
        gcb = 0; gcr = 0;
        if (!rst && bus.div_rfd) begin
            if (bus.cb_req_valid && bus.cr_req_valid) begin
                if (prio_cr) gcr = 1; else gcb = 1;
            end else if (bus.cb_req_valid) gcb = 1;
            else if (bus.cr_req_valid) gcr = 1;
        end
        edd = gcb ? bus.cb_dividend : gcr ? bus.cr_dividend : '0;
        eds = gcb ? bus.cb_divisor  : gcr ? bus.cr_divisor  : '0;
        check("cb_req_ready", 32'(bus.cb_req_ready), 32'(gcb));
        check("cr_req_ready", 32'(bus.cr_req_ready), 32'(gcr));
        check("div_nd", 32'(bus.div_nd), 32'(gcb | gcr));
        check("div_dividend", 32'(bus.div_dividend), 32'(edd));
        check("div_divisor", 32'(bus.div_divisor), 32'(eds));
        if (!rst) begin
            ecbv = 0; ecrv = 0;
            ebusy = (sb.size() != 0);
            if (sb.size() != 0 && sb[0].due == cyc) begin
                if (sb[0].side) begin ecrv = 1; last_cr = sb[0].q; end
                else            begin ecbv = 1; last_cb = sb[0].q; end
                void'(sb.pop_front());
            end
            check("cb_res_valid", 32'(bus.cb_res_valid), 32'(ecbv));
            check("cr_res_valid", 32'(bus.cr_res_valid), 32'(ecrv));
            check("cb_res_quotient", 32'(bus.cb_res_quotient), 32'(last_cb));
            check("cr_res_quotient", 32'(bus.cr_res_quotient), 32'(last_cr));
            check("busy", 32'(bus.busy), 32'(ebusy));
            if (gcb || gcr) begin
                exp_t e;
                e.side = gcr;
                e.q    = (eds == '0) ? {DW{1'b1}} : edd / eds;
                e.due  = cyc + LAT + 1;
                sb.push_back(e);
                prio_cr = gcb;
            end
        end else begin
            sb.delete();
            last_cb = '0; last_cr = '0; prio_cr = 0;
        end
        last_gcb = gcb; last_gcr = gcr;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        drive(0, 0, 0, 0, 0, 0, 1);
        rst = 1; tick(); tick(); rst = 0;

        // single Cb request
        drive(1, 1000, 8, 0, 0, 0, 1); tick();
        idle(24);

        // both requesting for 6 cycles from a fresh pointer
        rst = 1; tick(); rst = 0;
        for (int i = 0; i < 6; i++) begin
            drive(1, 100 + i, 3, 1, 200 + i, 7, 1); tick();
        end
        idle(24);

        // Cr-only back-to-back stream
        for (int i = 1; i <= 4; i++) begin
            drive(0, 0, 0, 1, 120, i, 1); tick();
        end
        idle(24);

        // divider not ready with both requesting, then release
        repeat (3) begin drive(1, 77, 7, 1, 99, 9, 0); tick(); end
        repeat (2) begin drive(1, 77, 7, 1, 99, 9, 1); tick(); end
        idle(24);

        // divide by zero followed by a normal Cr request
        drive(1, 500, 0, 0, 0, 0, 1); tick();
        drive(0, 0, 0, 1, 500, 5, 1); tick();
        idle(24);

        // reset with three slots in flight, then a fresh request
        drive(1, 1, 1, 0, 0, 0, 1); tick();
        drive(0, 0, 0, 1, 2, 1, 1); tick();
        drive(1, 3, 1, 0, 0, 0, 1); tick();
        idle(3);
        rst = 1; tick(); rst = 0;
        drive(1, 64, 4, 0, 0, 0, 1); tick();
        idle(24);

        // randomized traffic; a pending request holds until accepted
        drive(0, 0, 0, 0, 0, 0, 1);
        last_gcb = 0; last_gcr = 0;
        for (int n = 0; n < 400; n++) begin
            if (!bus.cb_req_valid || last_gcb) begin
                bus.cb_req_valid = 1'($urandom_range(0, 1));
                bus.cb_dividend  = DW'($urandom);
                bus.cb_divisor   = ($urandom_range(0, 7) == 0) ? '0 : DW'($urandom_range(1, 1000));
            end
            if (!bus.cr_req_valid || last_gcr) begin
                bus.cr_req_valid = 1'($urandom_range(0, 1));
                bus.cr_dividend  = DW'($urandom);
                bus.cr_divisor   = ($urandom_range(0, 7) == 0) ? '0 : DW'($urandom_range(1, 1000));
            end
            bus.div_rfd = ($urandom_range(0, 3) != 0);
            tick();
        end
        idle(25);
        check("drained", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
